// File: rtl/dma_block_engine.sv
// dma_block_engine: responder end of the 1024-bit DMA interface; moves one block as 16 x 64-bit
// memory beats. Defining DMA_PERF_CNT_EN adds the perf_cycles output (start-to-done cycle count).
module dma_block_engine #(
  parameter int BLK_W   = 1024,
  parameter int BUS_W   = 64,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_rx_start,
  input  logic [ADDR_W-1:0] dma_rx_address,
  output logic [BLK_W-1:0]  dma_rx_data,
  input  logic              dma_tx_start,
  input  logic [ADDR_W-1:0] dma_tx_address,
  input  logic [BLK_W-1:0]  dma_tx_data,
  output logic              dma_done,
  output logic              dma_idle,
  output logic              dma_error,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [BUS_W-1:0]  mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [BUS_W-1:0]  mem_resp_rdata,
  input  logic              mem_resp_err
`ifdef DMA_PERF_CNT_EN
  , output logic [31:0]     perf_cycles
`endif
);

  localparam int BEATS   = BLK_W / BUS_W;
  localparam int IDX_W   = $clog2(BEATS);
  localparam int CNT_W   = IDX_W + 1;
  localparam int TO_W    = $clog2(TIMEOUT) + 1;
  localparam int ALIGN_W = $clog2(BUS_W / 8);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BUS_W / 8);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t             state_r;
  logic [BLK_W-1:0]   tx_buf_r;
  logic [CNT_W-1:0]   issue_cnt_r;
  logic [CNT_W-1:0]   resp_cnt_r;
  logic [TO_W-1:0]    to_cnt_r;
  logic               err_flag_r;
  logic               misalign_r;

  logic               start_s;
  logic [ADDR_W-1:0]  base_s;
  logic               busy_s;
  logic               req_hs_s;
  logic               resp_hs_s;
  logic               last_resp_s;
  logic               to_hit_s;
  logic               finish_s;
  logic               fail_s;
  logic [IDX_W-1:0]   next_idx_s;
  logic [IDX_W-1:0]   resp_idx_s;

  assign start_s     = (state_r == S_IDLE) && (dma_rx_start || dma_tx_start);
  assign base_s      = dma_rx_start ? dma_rx_address : dma_tx_address;
  assign busy_s      = (state_r == S_READ) || (state_r == S_WRITE);
  assign req_hs_s    = mem_req_valid && mem_req_ready;
  assign resp_hs_s   = busy_s && !misalign_r && mem_resp_valid;
  assign last_resp_s = resp_hs_s && (resp_cnt_r == CNT_W'(BEATS - 1));
  assign to_hit_s    = (to_cnt_r == TO_W'(TIMEOUT - 1)) && !req_hs_s && !resp_hs_s;
  assign finish_s    = busy_s && (misalign_r || to_hit_s || last_resp_s);
  assign fail_s      = misalign_r || to_hit_s || err_flag_r || (resp_hs_s && mem_resp_err);
  assign next_idx_s  = issue_cnt_r[IDX_W-1:0] + IDX_W'(1);
  assign resp_idx_s  = resp_cnt_r[IDX_W-1:0];

  // Transfer FSM: start sampling, request issue, response collection, completion/abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      tx_buf_r      <= '0;
      issue_cnt_r   <= '0;
      resp_cnt_r    <= '0;
      to_cnt_r      <= '0;
      err_flag_r    <= 1'b0;
      misalign_r    <= 1'b0;
      dma_rx_data   <= '0;
      dma_done      <= 1'b0;
      dma_idle      <= 1'b1;
      dma_error     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      dma_done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            state_r       <= dma_rx_start ? S_READ : S_WRITE;
            dma_idle      <= 1'b0;
            dma_error     <= 1'b0;
            err_flag_r    <= 1'b0;
            issue_cnt_r   <= '0;
            resp_cnt_r    <= '0;
            to_cnt_r      <= '0;
            misalign_r    <= (base_s[ALIGN_W-1:0] != '0);
            mem_req_valid <= (base_s[ALIGN_W-1:0] == '0);
            mem_req_write <= !dma_rx_start;
            mem_req_addr  <= base_s;
            mem_req_wdata <= dma_rx_start ? '0 : dma_tx_data[BUS_W-1:0];
            if (!dma_rx_start) begin
              tx_buf_r <= dma_tx_data;
            end
          end
        end
        S_READ, S_WRITE: begin
          if (finish_s) begin
            state_r       <= S_IDLE;
            dma_done      <= 1'b1;
            dma_idle      <= 1'b1;
            dma_error     <= fail_s;
            mem_req_valid <= 1'b0;
            if (resp_hs_s && (state_r == S_READ)) begin
              dma_rx_data[resp_idx_s*BUS_W +: BUS_W] <= mem_resp_rdata;
            end
          end else begin
            to_cnt_r <= (req_hs_s || resp_hs_s) ? '0 : to_cnt_r + TO_W'(1);
            if (req_hs_s) begin
              issue_cnt_r <= issue_cnt_r + CNT_W'(1);
              if (issue_cnt_r == CNT_W'(BEATS - 1)) begin
                mem_req_valid <= 1'b0;
              end else begin
                mem_req_addr <= mem_req_addr + STRIDE;
                if (state_r == S_WRITE) begin
                  mem_req_wdata <= tx_buf_r[next_idx_s*BUS_W +: BUS_W];
                end
              end
            end
            // Responses may overlap later requests; errored read beats are still stored
            if (resp_hs_s) begin
              resp_cnt_r <= resp_cnt_r + CNT_W'(1);
              if (mem_resp_err) begin
                err_flag_r <= 1'b1;
              end
              if (state_r == S_READ) begin
                dma_rx_data[resp_idx_s*BUS_W +: BUS_W] <= mem_resp_rdata;
              end
            end
          end
        end
        default: begin
          state_r       <= S_IDLE;
          dma_idle      <= 1'b1;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMA_PERF_CNT_EN
  logic [31:0] perf_cnt_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Cycle counter from start edge to done pulse inclusive, published at done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt_r  <= 32'd0;
      perf_cycles <= 32'd0;
    end else if (start_s) begin
      perf_cnt_r <= 32'd1;
    end else if (finish_s) begin
      perf_cycles <= sat_inc(perf_cnt_r);
    end else if (busy_s) begin
      perf_cnt_r <= sat_inc(perf_cnt_r);
    end
  end
`endif

endmodule
